// File: rtl/seg7_pkg.sv
// seg7_pkg: shared active-low seven-segment glyph constants (bit6..bit0 = g..a)
package seg7_pkg;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [15:0][6:0] SEG_GLYPHS = {
        SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
        SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
    };
    // Nibbles above 9 show as hex letters only in hex mode, otherwise blank.
    function automatic logic [6:0] seg7_glyph(input logic [3:0] nib, input logic hex);
        return (!hex && nib > 4'd9) ? SEG_BLANK : SEG_GLYPHS[nib];
    endfunction
endpackage

// File: rtl/seg7_hex_lut.sv
// seg7_hex_lut: combinational nibble to active-low glyph decoder
module seg7_hex_lut
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    input  logic       hex,
    output logic [6:0] seg
);
    assign seg = seg7_glyph(nib, hex);
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed seven-segment scanner with guard band and tear-free updates
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 50000,
    parameter int GUARD      = 16
) (
    input  logic                    iCLK,
    input  logic                    iRST_N,
    input  logic [4*NUM_DIGITS-1:0] iDATA,
    input  logic                    iLOAD,
    input  logic [NUM_DIGITS-1:0]   iDP,
    input  logic                    iHEX,
    input  logic                    iLZB,
    output logic [6:0]              oSEG7,
    output logic                    oDP,
    output logic [NUM_DIGITS-1:0]   oDIG,
    output logic                    oFRAME
);
    localparam int PW = $clog2(CLK_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] GUARD_END  = PW'(GUARD);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]           presc_q, presc_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] pend_data_q, pend_data_d, disp_data_q, disp_data_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
    logic                    pend_hex_q, pend_hex_d, disp_hex_q, disp_hex_d;
    logic                    pend_lzb_q, pend_lzb_d, disp_lzb_q, disp_lzb_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   dig_q, dig_d;
    logic                    frame_q, frame_d;
    logic                    wrap, xfer, guard, blank, lead;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic [3:0]              cur_nib;
    logic [6:0]              glyph;

    seg7_hex_lut u_lut (
        .nib (cur_nib),
        .hex (disp_hex_q),
        .seg (glyph)
    );

    // Scan timing, pending/display handoff at frame wrap, and next output values.
    always_comb begin
        wrap        = presc_q == PRESC_LAST;
        xfer        = wrap && idx_q == IDX_LAST;
        presc_d     = wrap ? '0 : presc_q + PW'(1);
        idx_d       = wrap ? (idx_q == IDX_LAST ? '0 : idx_q + IW'(1)) : idx_q;
        pend_data_d = iLOAD ? iDATA : pend_data_q;
        pend_dp_d   = iLOAD ? iDP : pend_dp_q;
        pend_hex_d  = iLOAD ? iHEX : pend_hex_q;
        pend_lzb_d  = iLOAD ? iLZB : pend_lzb_q;
        disp_data_d = xfer ? pend_data_d : disp_data_q;
        disp_dp_d   = xfer ? pend_dp_d : disp_dp_q;
        disp_hex_d  = xfer ? pend_hex_d : disp_hex_q;
        disp_lzb_d  = xfer ? pend_lzb_d : disp_lzb_q;
        lead        = 1'b1;
        lz_mask     = '0;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            lead       = lead && disp_data_q[4*k +: 4] == 4'd0 && !disp_dp_q[k];
            lz_mask[k] = lead;
        end
        cur_nib = disp_data_q[{idx_q, 2'b00} +: 4];
        guard   = presc_q < GUARD_END;
        blank   = disp_lzb_q && lz_mask[idx_q];
        seg_d   = (guard || blank) ? SEG_BLANK : glyph;
        dp_d    = guard || blank || !disp_dp_q[idx_q];
        dig_d   = guard ? '1 : ~(NUM_DIGITS'(1) << idx_q);
        frame_d = presc_q == '0 && idx_q == '0;
    end

    // State and registered outputs, cleared asynchronously on reset.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            presc_q     <= '0;
            idx_q       <= '0;
            pend_data_q <= '0;
            pend_dp_q   <= '0;
            pend_hex_q  <= 1'b0;
            pend_lzb_q  <= 1'b0;
            disp_data_q <= '0;
            disp_dp_q   <= '0;
            disp_hex_q  <= 1'b0;
            disp_lzb_q  <= 1'b0;
            seg_q       <= SEG_BLANK;
            dp_q        <= 1'b1;
            dig_q       <= '1;
            frame_q     <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            pend_data_q <= pend_data_d;
            pend_dp_q   <= pend_dp_d;
            pend_hex_q  <= pend_hex_d;
            pend_lzb_q  <= pend_lzb_d;
            disp_data_q <= disp_data_d;
            disp_dp_q   <= disp_dp_d;
            disp_hex_q  <= disp_hex_d;
            disp_lzb_q  <= disp_lzb_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            dig_q       <= dig_d;
            frame_q     <= frame_d;
        end
    end

    assign oSEG7  = seg_q;
    assign oDP    = dp_q;
    assign oDIG   = dig_q;
    assign oFRAME = frame_q;
endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (legal 2..8).
REQ-002 SHALL have parameter CLK_DIV, default 50000, clock cycles per digit slot (legal >= GUARD+2).
REQ-003 SHALL have parameter GUARD, default 16, cycles at slot start with all digit enables off (anti-ghosting).
REQ-004 SHALL have port iCLK, input, 1, single clock; all logic on rising edge.
REQ-005 SHALL have port iRST_N, input, 1, reset; asynchronous assert, active-low.
REQ-006 SHALL have port iDATA, input, 4*NUM_DIGITS, nibble k = digit k; digit 0 least significant.
REQ-007 SHALL have port iLOAD, input, 1, one-cycle strobe capturing iDATA, iDP, iHEX, iLZB.
REQ-008 SHALL have port iDP, input, NUM_DIGITS, decimal point per digit, 1 = lit.
REQ-009 SHALL have port iHEX, input, 1, 1 = hex glyphs for 10..15, 0 = decimal (10..15 blank).
REQ-010 SHALL have port iLZB, input, 1, 1 = leading-zero blanking enabled.
REQ-011 SHALL have port oSEG7, output, 7, active-low segments, bit6..bit0 = g..a.
REQ-012 SHALL have port oDP, output, 1, active-low decimal point.
REQ-013 SHALL have port oDIG, output, NUM_DIGITS, active-low one-hot digit enable.
REQ-014 SHALL have port oFRAME, output, 1, one-cycle pulse at start of each full scan frame.

Function
REQ-015 SHALL run a prescaler counting 0..CLK_DIV-1 and wrapping; wrap advances digit index 0..NUM_DIGITS-1, wrapping to 0.
REQ-016 SHALL hold oDIG all high while prescaler < GUARD, and drive oDIG[idx] low otherwise.
REQ-017 SHALL capture inputs on iLOAD into a pending register; pending SHALL transfer to the display register only on the cycle the index wraps to 0 (tear-free frames).
REQ-018 SHALL, on iLOAD coinciding with the transfer cycle, transfer the newly presented values directly; last iLOAD before a transfer wins.
REQ-019 SHALL pulse oFRAME on the cycle index 0 slot begins (prescaler 0, index 0).
REQ-020 SHALL decode 0..9 as 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
REQ-021 SHALL decode 10..15 with hex mode as A 0001000, b 0000011, C 1000110, d 0100001, E 0000110, F 0001110; without hex mode as 1111111.
REQ-022 SHALL, with blanking enabled, blank (1111111, DP off) every digit above the most significant nonzero digit; digit 0 always displayed; a lit DP on a digit stops blanking at that digit.
REQ-023 SHALL register oSEG7, oDP, oDIG so all change on the same edge; latency from index change to outputs is one cycle.
REQ-024 SHALL drive oSEG7 = 1111111 and oDP = 1 during guard cycles.

Reset
REQ-025 SHALL, on iRST_N low, force prescaler 0, index 0, pending and display registers 0, iHEX/iLZB copies 0, oSEG7 1111111, oDP 1, oDIG all 1, oFRAME 0.
REQ-026 SHALL, on reset mid-scan, abandon the frame; first pending transfer occurs at next index wrap after release.

Structure
REQ-027 SHALL place segment glyph constants (SEG_BLANK, digit and hex glyphs) in shared package seg7_pkg.
REQ-028 SHALL instantiate combinational sub-module seg7_hex_lut (nibble, hex mode -> 7-bit glyph).

Verification
REQ-029 SHALL cover: NUM_DIGITS=4, CLK_DIV=8, GUARD=2, reset release -> oDIG sequence 1110,1101,1011,0111 each active 6 of 8 cycles, oFRAME every 32 cycles.
REQ-030 SHALL cover: iLOAD iDATA=16'h00A5, iHEX=1, iLZB=1 -> digit0 0010010, digit1 0001000, digits 2-3 1111111, visible only from next frame.
REQ-031 SHALL cover: iDATA=16'h00A5, iHEX=0, iLZB=0 -> digit1 1111111, digits 2-3 show 1000000.
REQ-032 SHALL cover: iDATA=16'h0000, iLZB=1, iDP=4'b0100 -> digit0 1000000, digit2 1000000 with oDP=0, digit1 shows 1000000, digit3 blank.
REQ-033 SHALL cover: two iLOADs (16'h1111 then 16'h2222) in one frame -> next frame shows only 2222; no mixed frame.
REQ-034 SHALL cover: iRST_N low during index 2 -> outputs at reset values within same cycle; scan restarts at index 0 after release.
